if_stage: RTL and testbench



---
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the fetch PC, picks the next PC from flush,
// branch-redirect and sequential sources, and drives the instruction SRAM.
module if_stage #(
    parameter int          FS_TO_DS_BUS_WD = 65,
    parameter logic [31:0] RESET_PC        = 32'h1C00_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                new_pc,
    input  logic [5:0]                 stall,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    output logic                       pc_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    output logic [31:0]                fetch_cnt
);

    localparam logic [5:0] ECODE_ADEF    = 6'h08;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        valid_r, valid_nxt;
    logic [31:0] pc_r, pc_nxt;
    logic        redir_pend, pend_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;
    logic [31:0] cnt_nxt;
    logic        if_stall;
    logic        excp_adef;
    logic [31:0] csr_vec_h;

    assign if_stall = stall[0];

    // Only the IF bit of the stall vector matters to this stage.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[5:1]};

    assign pc_valid        = valid_r;
    assign excp_adef       = valid_r & (pc_r[1:0] != 2'b00);
    assign csr_vec_h       = excp_adef ? {17'b0, ESUBCODE_ADEF, ECODE_ADEF} : 32'b0;
    assign inst_sram_en    = valid_r & ~excp_adef;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = pc_r;
    assign inst_sram_wdata = 32'b0;
    assign fs_to_ds_bus    = {csr_vec_h, excp_adef, pc_r};

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_nxt    = state;
        valid_nxt    = valid_r;
        pc_nxt       = pc_r;
        pend_nxt     = redir_pend;
        redir_pc_nxt = redir_pc;
        cnt_nxt      = fetch_cnt;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                valid_nxt = 1'b1;
            end
            RUN: begin
                if (flush) begin
                    pc_nxt   = new_pc;
                    pend_nxt = 1'b0;
                end else if (if_stall) begin
                    // A branch resolved while IF is frozen is parked until the stall lifts.
                    if (br_taken) begin
                        pend_nxt     = 1'b1;
                        redir_pc_nxt = br_target;
                    end
                end else if (redir_pend) begin
                    pc_nxt   = br_taken ? br_target : redir_pc;
                    pend_nxt = 1'b0;
                end else if (br_taken) begin
                    pc_nxt = br_target;
                end else begin
                    pc_nxt = pc_r + 32'd4;
                end
                if (inst_sram_en && !if_stall) begin
                    cnt_nxt = fetch_cnt + 32'd1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state      <= BOOT;
            valid_r    <= 1'b0;
            pc_r       <= RESET_PC;
            redir_pend <= 1'b0;
            redir_pc   <= 32'b0;
            fetch_cnt  <= 32'b0;
        end else begin
            state      <= state_nxt;
            valid_r    <= valid_nxt;
            pc_r       <= pc_nxt;
            redir_pend <= pend_nxt;
            redir_pc   <= redir_pc_nxt;
            fetch_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural fetch model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        pc_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    if_stage #(.FS_TO_DS_BUS_WD(65), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .new_pc          (new_pc),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .pc_valid        (pc_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: boot flag, valid, PC, parked branch, fetch count.
    bit          m_boot = 1'b1;
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = RESET_PC;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'b0;
    logic [31:0] m_cnt = 32'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_boot = 1'b1; m_valid = 1'b0; m_pc = RESET_PC;
            m_pend = 1'b0; m_pend_pc = 32'b0; m_cnt = 32'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_valid = 1'b1;
        end else begin
            bit fetched;
            fetched = m_valid && (m_pc % 4 == 0) && !stall[0];
            if (flush) begin
                m_pc = new_pc;
                m_pend = 1'b0;
            end else if (stall[0]) begin
                if (br_taken) begin
                    m_pend = 1'b1;
                    m_pend_pc = br_target;
                end
            end else begin
                if (br_taken)    m_pc = br_target;
                else if (m_pend) m_pc = m_pend_pc;
                else             m_pc = m_pc + 4;
                m_pend = 1'b0;
            end
            if (fetched) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit          adef;
            logic [64:0] bus;
            adef = m_valid && (m_pc % 4 != 0);
            bus  = {(adef ? 32'h0000_0008 : 32'h0), adef, m_pc};
            check("model_pc_valid", {64'b0, pc_valid}, {64'b0, m_valid});
            check("model_sram_en", {64'b0, inst_sram_en}, {64'b0, (m_valid && !adef)});
            check("model_sram_addr", {33'b0, inst_sram_addr}, {33'b0, m_pc});
            check("model_bus", fs_to_ds_bus, bus);
            check("model_fetch_cnt", {33'b0, fetch_cnt}, {33'b0, m_cnt});
            check("model_sram_we", {61'b0, inst_sram_we}, 65'b0);
            check("model_sram_wdata", {33'b0, inst_sram_wdata}, 65'b0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] addr, input logic [31:0] cnt);
        check({name, "_addr"}, {33'b0, inst_sram_addr}, {33'b0, addr});
        check({name, "_cnt"}, {33'b0, fetch_cnt}, {33'b0, cnt});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; new_pc = 32'b0; stall = 6'b0;
        br_taken = 1'b0; br_target = 32'b0;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        check("rst_pc_valid", {64'b0, pc_valid}, 65'b0);
        check("rst_sram_en", {64'b0, inst_sram_en}, 65'b0);
        check("rst_bus", fs_to_ds_bus, {32'b0, 1'b0, 32'h1C00_0000});
        expect_fetch("rst", 32'h1C00_0000, 32'd0);
        reset = 1'b1;
        check("boot_pc_valid", {64'b0, pc_valid}, 65'b0);

        // Sequential fetch after release.
        tick(); check("run_pc_valid", {64'b0, pc_valid}, 65'b1);
        expect_fetch("seq0", 32'h1C00_0000, 32'd0);
        tick(); expect_fetch("seq1", 32'h1C00_0004, 32'd1);
        tick(); expect_fetch("seq2", 32'h1C00_0008, 32'd2);
        br_taken = 1'b1; br_target = 32'h1C00_0100;
        tick(); expect_fetch("br0", 32'h1C00_0100, 32'd3);
        br_taken = 1'b0;
        tick(); expect_fetch("br1", 32'h1C00_0104, 32'd4);

        // Three-cycle stall with a branch in the second stalled cycle.
        stall = 6'b000001;
        tick(); expect_fetch("stall1", 32'h1C00_0104, 32'd4);
        br_taken = 1'b1; br_target = 32'h1C00_0200;
        tick(); expect_fetch("stall2", 32'h1C00_0104, 32'd4);
        br_taken = 1'b0;
        tick(); expect_fetch("stall3", 32'h1C00_0104, 32'd4);
        check("stall_en", {64'b0, inst_sram_en}, 65'b1);
        stall = 6'b0;
        tick(); expect_fetch("stall_redir", 32'h1C00_0200, 32'd5);

        // Park a branch, then reset asynchronously mid-cycle.
        stall = 6'b000001; br_taken = 1'b1; br_target = 32'h1C00_0300;
        tick(); expect_fetch("park", 32'h1C00_0200, 32'd5);
        br_taken = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_pc_valid", {64'b0, pc_valid}, 65'b0);
        expect_fetch("arst", 32'h1C00_0000, 32'd0);
        stall = 6'b0;
        tick(); reset = 1'b1;
        check("reboot_pc_valid", {64'b0, pc_valid}, 65'b0);
        tick(); check("rerun_pc_valid", {64'b0, pc_valid}, 65'b1);
        expect_fetch("rerun", 32'h1C00_0000, 32'd0);

        // Flush during a stall discards a parked branch.
        stall = 6'b000001; br_taken = 1'b1; br_target = 32'h1C00_0300;
        tick(); expect_fetch("park2", 32'h1C00_0000, 32'd0);
        br_taken = 1'b0; flush = 1'b1; new_pc = 32'h1C00_8000;
        tick(); expect_fetch("flush", 32'h1C00_8000, 32'd0);
        flush = 1'b0; stall = 6'b0;
        tick(); expect_fetch("post_flush", 32'h1C00_8004, 32'd1);

        // Misaligned branch target raises ADEF and suppresses the fetch.
        br_taken = 1'b1; br_target = 32'h1C00_0102;
        tick(); expect_fetch("adef", 32'h1C00_0102, 32'd2);
        check("adef_flag", {64'b0, fs_to_ds_bus[32]}, 65'b1);
        check("adef_csr", {33'b0, fs_to_ds_bus[64:33]}, {33'b0, 32'h0000_0008});
        check("adef_en", {64'b0, inst_sram_en}, 65'b0);
        br_taken = 1'b0;
        tick(); expect_fetch("adef_next", 32'h1C00_0106, 32'd2);
        br_taken = 1'b1; br_target = 32'h1C00_0400;
        tick(); expect_fetch("realign", 32'h1C00_0400, 32'd2);

        // Live branch beats a parked one when the stall lifts.
        stall = 6'b000001; br_target = 32'h1C00_0500;
        tick(); expect_fetch("park3", 32'h1C00_0400, 32'd2);
        stall = 6'b0; br_target = 32'h1C00_0600;
        tick(); expect_fetch("br_over_pend", 32'h1C00_0600, 32'd3);

        // PC wraps past the top of the address space.
        br_target = 32'hFFFF_FFFC;
        tick(); expect_fetch("top", 32'hFFFF_FFFC, 32'd4);
        br_taken = 1'b0;
        tick(); expect_fetch("wrap", 32'h0000_0000, 32'd5);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
